// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl upload path: FSM state encoding and the
// hps_io byte-address width.
package ioctl_pkg;

  localparam int IOCTL_ADDR_W = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACTIVE,
    ST_FETCH,
    ST_WAIT
  } state_t;

  // States in which a served session is open (a fall of ioctl_upload ends it with done).
  function automatic logic in_session(input state_t s);
    return (s == ST_ACTIVE) || (s == ST_FETCH) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/ioctl_rd_delay.sv
// Memory read latency tracker: counts MEM_LAT cycles from the issue of a read
// and captures mem_dout (or the FILL byte for out-of-range reads) into dout.
module ioctl_rd_delay #(
  parameter int         MEM_LAT = 1,
  parameter logic [7:0] FILL    = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       flush,
  input  logic       fill_load,
  input  logic [7:0] mem_dout,
  output logic       fire,
  output logic [7:0] dout
);

  logic       run;
  logic [1:0] cnt;
  logic       load;

  // fire marks the cycle in which mem_dout holds the requested byte.
  assign fire = run && (cnt == 2'd0);
  assign load = (fire && !flush) || fill_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= 2'd0;
    end else if (flush) begin
      run <= 1'b0;
    end else if (start) begin
      // NOTE: non-blocking assignments keep every register update on the clock edge, race-free.
      run <= 1'b1;
      cnt <= 2'(MEM_LAT - 1);
    end else if (run) begin
      if (cnt == 2'd0) run <= 1'b0;
      else             cnt <= cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       dout <= 8'h00;
    else if (load) dout <= fire ? mem_dout : FILL;
  end

endmodule

// File: rtl/ioctl_uploader.sv
// Serves hps_io upload reads from a latency-MEM_LAT memory for one ioctl index.
// Define UPLOAD_CHECKSUM_EN to add the per-session byte checksum output.
module ioctl_uploader
  import ioctl_pkg::*;
#(
  parameter int          ADDR_W   = 17,
  parameter logic [7:0]  UP_INDEX = 8'd4,
  parameter int unsigned LENGTH   = 17'h1_0000,
  parameter int          MEM_LAT  = 1,
  parameter logic [7:0]  FILL     = 8'hFF
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    save_req,
  output logic                    ioctl_upload_req,
  input  logic                    ioctl_upload,
  input  logic [7:0]              ioctl_index,
  input  logic                    ioctl_rd,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  output logic [7:0]              ioctl_din,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd,
  input  logic [7:0]              mem_dout,
  output logic                    busy,
  output logic                    done
`ifdef UPLOAD_CHECKSUM_EN
  ,
  output logic [7:0]              checksum
`endif
);

  localparam logic [IOCTL_ADDR_W-1:0] LIMIT = IOCTL_ADDR_W'(LENGTH);

  state_t                  state, state_nx;
  logic                    upload_q;
  logic                    pend_valid;
  logic [IOCTL_ADDR_W-1:0] pend_addr;
  logic                    sess, rd_ok, abort;
  logic                    req_valid, req_in_range;
  logic [IOCTL_ADDR_W-1:0] req_addr;
  logic                    issue, fill_load, fire;

  assign sess  = ioctl_upload && (ioctl_index == UP_INDEX);
  assign rd_ok = ioctl_rd && sess;
  assign abort = (state != ST_IDLE) && upload_q && !ioctl_upload;

  // A fresh strobe in ACTIVE supersedes anything still pending.
  assign req_valid    = rd_ok || pend_valid;
  assign req_addr     = rd_ok ? ioctl_addr : pend_addr;
  assign req_in_range = req_addr < LIMIT;
  assign issue        = (state == ST_ACTIVE) && !abort && req_valid && req_in_range;
  assign fill_load    = (state == ST_ACTIVE) && !abort && req_valid && !req_in_range;

  assign ioctl_upload_req = (state == ST_REQ);
  assign busy             = (state == ST_FETCH) || (state == ST_WAIT) || pend_valid;

  always_comb begin
    // NOTE: assigning the default first means no path leaves state_nx unassigned, so no latch.
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (sess) state_nx = ST_ACTIVE;
                 else if (save_req) state_nx = ST_REQ;
      ST_REQ:    if (sess) state_nx = ST_ACTIVE;
      ST_ACTIVE: if (issue) state_nx = ST_FETCH;
      ST_FETCH:  state_nx = fire ? ST_ACTIVE : ST_WAIT;
      ST_WAIT:   if (fire) state_nx = ST_ACTIVE;
      default:   state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      upload_q   <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      done       <= 1'b0;
    end else begin
      state    <= state_nx;
      upload_q <= ioctl_upload;
      mem_rd   <= issue;
      done     <= abort && in_session(state);
      if (issue) mem_addr <= req_addr[ADDR_W-1:0];

      if (abort) begin
        pend_valid <= 1'b0;
      end else if (((state == ST_FETCH) || (state == ST_WAIT)) && rd_ok) begin
        pend_valid <= 1'b1;
        pend_addr  <= ioctl_addr;
      end else if (state == ST_ACTIVE) begin
        pend_valid <= 1'b0;
      end
    end
  end

  ioctl_rd_delay #(
    .MEM_LAT (MEM_LAT),
    .FILL    (FILL)
  ) u_rd_delay (
    .clk       (clk_sys),
    .rst       (reset),
    .start     (issue),
    .flush     (abort),
    .fill_load (fill_load),
    .mem_dout  (mem_dout),
    .fire      (fire),
    .dout      (ioctl_din)
  );

`ifdef UPLOAD_CHECKSUM_EN
  logic       enter_active, cs_load;
  logic [7:0] cs_byte;

  // Mirrors the ioctl_din load condition so FILL bytes are summed too.
  assign enter_active = ((state == ST_IDLE) || (state == ST_REQ)) && (state_nx == ST_ACTIVE);
  assign cs_load      = (fire && !abort) || fill_load;
  assign cs_byte      = fire ? mem_dout : FILL;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)             checksum <= 8'h00;
    else if (enter_active) checksum <= 8'h00;
    else if (cs_load)      checksum <= checksum + cs_byte;
  end
`endif

endmodule

// File: tb/tb_ioctl_uploader.sv
// Directed bench for ioctl_uploader with MEM_LAT=2; inputs change after the
// rising edge, outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_ioctl_uploader;
  import ioctl_pkg::*;

  localparam int ADDR_W  = 17;
  localparam int MEM_LAT = 2;

  logic              clk_sys = 1'b0;
  logic              reset, save_req, ioctl_upload_req, ioctl_upload, ioctl_rd;
  logic              mem_rd, busy, done;
  logic [7:0]        ioctl_index, ioctl_din, mem_dout;
  logic [24:0]       ioctl_addr;
  logic [ADDR_W-1:0] mem_addr;
`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  logic [7:0] mem [0:15];
  int n_checks = 0;
  int n_errors = 0;
  int mem_rd_cnt = 0;
  int done_cnt = 0;
  int rd_base, done_base;

  always #5 clk_sys = ~clk_sys;

  ioctl_uploader #(
    .ADDR_W   (ADDR_W),
    .UP_INDEX (8'd4),
    .LENGTH   (17'h1_0000),
    .MEM_LAT  (MEM_LAT),
    .FILL     (8'hFF)
  ) dut (
    .clk_sys          (clk_sys),
    .reset            (reset),
    .save_req         (save_req),
    .ioctl_upload_req (ioctl_upload_req),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_rd         (ioctl_rd),
    .ioctl_addr       (ioctl_addr),
    .ioctl_din        (ioctl_din),
    .mem_addr         (mem_addr),
    .mem_rd           (mem_rd),
    .mem_dout         (mem_dout),
    .busy             (busy),
    .done             (done)
`ifdef UPLOAD_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  // Memory: data is sampled MEM_LAT edges after the edge that launches mem_rd.
  always @(posedge clk_sys) if (mem_rd) mem_dout <= mem[mem_addr[3:0]];

  always @(posedge clk_sys) begin
    if (mem_rd) mem_rd_cnt <= mem_rd_cnt + 1;
    if (done)   done_cnt   <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  // Issue a one-cycle read and wait until its byte has reached ioctl_din.
  task automatic do_read(input logic [24:0] addr);
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    step();
    ioctl_rd = 1'b0;
    cycles(3);
  endtask

  // Back-to-back expectations, slots 1..6 after the first strobe.
  logic       b_rd   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] b_addr [6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
  logic       b_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] b_din  [6] = '{8'h3C, 8'h3C, 8'h11, 8'h11, 8'h11, 8'h22};

  initial begin
    reset = 1'b1; save_req = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h5A; mem[3] = 8'hA5;
    mem[4] = 8'h80; mem[5] = 8'h81; mem[15] = 8'h3C;

    // Reset values
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_upload_req", 32'(ioctl_upload_req), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_din", 32'(ioctl_din), 32'h00);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    step();
    reset = 1'b0;
    step();

    // Request, then session rises 5 cycles later
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      check("req_upload_req_high", 32'(ioctl_upload_req), 32'd1);
      if (i == 4) begin
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd4;
      end
      step();
    end
    @(negedge clk_sys);
    check("req_upload_req_low", 32'(ioctl_upload_req), 32'd0);
    check("req_state_active", 32'(dut.state), 32'(ST_ACTIVE));
    step();

    // Latency with MEM_LAT=2
    rd_base = mem_rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'd3;
    step();
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("lat_mem_rd_p1", 32'(mem_rd), 32'd1);
    check("lat_mem_addr_p1", 32'(mem_addr), 32'd3);
    check("lat_busy_p1", 32'(busy), 32'd1);
    step();
    @(negedge clk_sys);
    check("lat_mem_rd_p2", 32'(mem_rd), 32'd0);
    check("lat_busy_p2", 32'(busy), 32'd1);
    check("lat_din_p2", 32'(ioctl_din), 32'h00);
    step();
    @(negedge clk_sys);
    check("lat_din_p3", 32'(ioctl_din), 32'hA5);
    check("lat_busy_p3", 32'(busy), 32'd0);
    check("lat_rd_count", 32'(mem_rd_cnt - rd_base), 32'd1);
    step();

    // Out of range: exactly LENGTH, and a bit-24 address that aliases in 17 bits
    rd_base = mem_rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'h001_0000;
    step();
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("oor_din", 32'(ioctl_din), 32'hFF);
    check("oor_mem_rd", 32'(mem_rd), 32'd0);
    check("oor_busy", 32'(busy), 32'd0);
    step();
    ioctl_rd = 1'b1; ioctl_addr = 25'h100_0003;
    step();
    ioctl_rd = 1'b0;
    cycles(3);
    @(negedge clk_sys);
    check("oor_wide_din", 32'(ioctl_din), 32'hFF);
    check("oor_no_mem_rd", 32'(mem_rd_cnt - rd_base), 32'd0);
    step();
    // Last in-range address
    ioctl_rd = 1'b1; ioctl_addr = 25'h000_FFFF;
    step();
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("edge_mem_rd", 32'(mem_rd), 32'd1);
    check("edge_mem_addr", 32'(mem_addr), 32'h0FFFF);
    step();
    step();
    @(negedge clk_sys);
    check("edge_din", 32'(ioctl_din), 32'h3C);
    step();

    // Back-to-back reads: second lands in the pending register
    rd_base = mem_rd_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'd0;
    step();
    for (int s = 0; s < 6; s++) begin
      @(negedge clk_sys);
      check($sformatf("b2b_mem_rd_%0d", s + 1), 32'(mem_rd), 32'(b_rd[s]));
      if (b_rd[s]) check($sformatf("b2b_mem_addr_%0d", s + 1), 32'(mem_addr), 32'(b_addr[s]));
      check($sformatf("b2b_busy_%0d", s + 1), 32'(busy), 32'(b_busy[s]));
      check($sformatf("b2b_din_%0d", s + 1), 32'(ioctl_din), 32'(b_din[s]));
      if (s == 0) ioctl_addr = 25'd1;
      else        ioctl_rd   = 1'b0;
      step();
    end
    check("b2b_rd_count", 32'(mem_rd_cnt - rd_base), 32'd2);

    // Abort during WAIT
    done_base = done_cnt;
    ioctl_rd = 1'b1; ioctl_addr = 25'd2;
    step();
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("abort_state_fetch", 32'(dut.state), 32'(ST_FETCH));
    step();
    @(negedge clk_sys);
    check("abort_state_wait", 32'(dut.state), 32'(ST_WAIT));
    ioctl_upload = 1'b0;
    step();
    @(negedge clk_sys);
    check("abort_din_held", 32'(ioctl_din), 32'h22);
    check("abort_state_idle", 32'(dut.state), 32'(ST_IDLE));
    check("abort_done_high", 32'(done), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    step();
    @(negedge clk_sys);
    check("abort_done_low", 32'(done), 32'd0);
    cycles(3);
    check("abort_done_count", 32'(done_cnt - done_base), 32'd1);
    check("abort_din_late", 32'(ioctl_din), 32'h22);

    // Reset in the middle of a fetch
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    step();
    @(negedge clk_sys);
    check("rmf_state_active", 32'(dut.state), 32'(ST_ACTIVE));
    step();
    ioctl_rd = 1'b1; ioctl_addr = 25'd3;
    step();
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("rmf_state_fetch", 32'(dut.state), 32'(ST_FETCH));
    reset = 1'b1;
    #1;
    check("rmf_din", 32'(ioctl_din), 32'h00);
    check("rmf_mem_rd", 32'(mem_rd), 32'd0);
    check("rmf_mem_addr", 32'(mem_addr), 32'h0);
    check("rmf_busy", 32'(busy), 32'd0);
    check("rmf_done", 32'(done), 32'd0);
    check("rmf_upload_req", 32'(ioctl_upload_req), 32'd0);
    check("rmf_state_idle", 32'(dut.state), 32'(ST_IDLE));
    ioctl_upload = 1'b0;
    cycles(2);
    reset = 1'b0;
    done_base = done_cnt;
    rd_base   = mem_rd_cnt;
    cycles(5);
    @(negedge clk_sys);
    check("rmf_post_din", 32'(ioctl_din), 32'h00);
    check("rmf_post_done", 32'(done_cnt - done_base), 32'd0);
    check("rmf_post_mem_rd", 32'(mem_rd_cnt - rd_base), 32'd0);
    step();

    // Reads for another index are ignored; save_req outside IDLE is ignored
    ioctl_upload = 1'b1; ioctl_index = 8'd7;
    step();
    ioctl_rd = 1'b1; ioctl_addr = 25'd3;
    step();
    ioctl_rd = 1'b0;
    cycles(3);
    @(negedge clk_sys);
    check("ign_state_idle", 32'(dut.state), 32'(ST_IDLE));
    check("ign_mem_rd", 32'(mem_rd_cnt - rd_base), 32'd0);
    check("ign_din", 32'(ioctl_din), 32'h00);
    step();
    ioctl_index = 8'd4;
    step();
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    @(negedge clk_sys);
    check("ign_save_req", 32'(ioctl_upload_req), 32'd0);
    check("ign_state_active", 32'(dut.state), 32'(ST_ACTIVE));
    step();

`ifdef UPLOAD_CHECKSUM_EN
    // Checksum over served bytes, held after done, cleared on next session
    check("cs_start", 32'(checksum), 32'h00);
    do_read(25'd4);
    do_read(25'd5);
    @(negedge clk_sys);
    check("cs_last_din", 32'(ioctl_din), 32'h81);
    check("cs_sum", 32'(checksum), 32'h01);
    step();
    do_read(25'h001_0000);
    @(negedge clk_sys);
    check("cs_fill_sum", 32'(checksum), 32'h00);
    step();
    do_read(25'd4);
    ioctl_upload = 1'b0;
    cycles(3);
    @(negedge clk_sys);
    check("cs_held", 32'(checksum), 32'h80);
    step();
    ioctl_upload = 1'b1;
    step();
    @(negedge clk_sys);
    check("cs_cleared", 32'(checksum), 32'h00);
    step();
`endif

    ioctl_upload = 1'b0;
    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ioctl_uploader.md
IOCTL_UPLOADER -- requirements
Module: ioctl_uploader

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, meaning the width of the memory read address.
REQ-002 SHALL have parameter UP_INDEX, default 8'd4, meaning the ioctl_index value this block serves.
REQ-003 SHALL have parameter LENGTH, default 17'h1_0000, meaning the number of valid bytes; addresses at or above it are out of range.
REQ-004 SHALL have parameter MEM_LAT, default 1, legal range 1..3, meaning the memory read latency in cycles.
REQ-005 SHALL have parameter FILL, default 8'hFF, meaning the byte returned for out-of-range addresses.
REQ-006 SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port save_req, input, 1 bit: single-cycle pulse from the core requesting an upload.
REQ-009 SHALL have port ioctl_upload_req, output, 1 bit: upload request to hps_io.
REQ-010 SHALL have port ioctl_upload, input, 1 bit: upload session active, from hps_io.
REQ-011 SHALL have port ioctl_index, input, 8 bits: file index of the current session.
REQ-012 SHALL have port ioctl_rd, input, 1 bit: single-cycle byte read strobe.
REQ-013 SHALL have port ioctl_addr, input, 25 bits: byte address qualified by ioctl_rd.
REQ-014 SHALL have port ioctl_din, output, 8 bits: byte returned to hps_io.
REQ-015 SHALL have port mem_addr, output, ADDR_W bits: memory read address.
REQ-016 SHALL have port mem_rd, output, 1 bit: memory read strobe.
REQ-017 SHALL have port mem_dout, input, 8 bits: memory data, valid MEM_LAT cycles after mem_rd.
REQ-018 SHALL have port busy, output, 1 bit: a fetch is in flight.
REQ-019 SHALL have port done, output, 1 bit: one-cycle pulse when a served session ends.

Function
REQ-020 SHALL implement an FSM with states IDLE, REQ, ACTIVE, FETCH and WAIT.
REQ-021 IDLE -> REQ on save_req, and ioctl_upload_req SHALL be high in REQ only.
REQ-022 REQ -> ACTIVE SHALL occur when ioctl_upload=1 and ioctl_index=UP_INDEX.
REQ-023 A matching session that starts while in IDLE SHALL also enter ACTIVE.
REQ-024 ACTIVE with ioctl_rd=1 and ioctl_addr < LENGTH -> FETCH: mem_addr SHALL be the low ADDR_W bits of ioctl_addr, and mem_rd SHALL be high for exactly one cycle.
REQ-025 FETCH -> WAIT, and WAIT SHALL count MEM_LAT-1 further cycles.
REQ-026 mem_dout SHALL be registered into ioctl_din on the MEM_LAT-th cycle after mem_rd, followed by a return to ACTIVE; read-to-ioctl_din latency is MEM_LAT+1 cycles.
REQ-027 An out-of-range read (ioctl_addr >= LENGTH, compared on the full 25 bits) SHALL load FILL into ioctl_din on the next cycle with no mem_rd, and the FSM SHALL stay in ACTIVE.
REQ-028 A single-entry pending register SHALL capture an ioctl_rd that arrives while in FETCH or WAIT.
REQ-029 The pending read SHALL be issued on the cycle the FSM returns to ACTIVE.
REQ-030 A further ioctl_rd while a read is already pending SHALL overwrite the pending address, so the last request wins.
REQ-031 busy SHALL be high in FETCH and WAIT, and whenever a read is pending.
REQ-032 ioctl_upload falling in any state other than IDLE SHALL abort in-flight and pending reads, discard late data, and return the FSM to IDLE.
REQ-033 done SHALL pulse on that fall only if the session had reached ACTIVE.
REQ-034 save_req while not in IDLE SHALL be ignored.
REQ-035 ioctl_rd while ioctl_upload=0 or ioctl_index!=UP_INDEX SHALL be ignored.

Reset
REQ-036 On reset, the FSM SHALL go to IDLE and ioctl_din SHALL become 8'h00.
REQ-037 On reset, ioctl_upload_req, mem_rd, busy and done SHALL become 0, mem_addr SHALL become 0 and the pending register SHALL be cleared.
REQ-038 Reset asserted mid-fetch SHALL produce no done pulse and no ioctl_din update after release.

Configuration
REQ-039 Macro UPLOAD_CHECKSUM_EN, when defined, SHALL add an output checksum, 8 bits: the modulo-256 sum of every byte loaded into ioctl_din during the current session, including FILL bytes.
REQ-040 checksum SHALL be cleared on entry to ACTIVE and held after done.
REQ-041 When UPLOAD_CHECKSUM_EN is undefined, the checksum port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-042 The FSM state enum and the 25-bit ioctl address width constant SHALL reside in a shared package, ioctl_pkg.
REQ-043 The MEM_LAT delay counter and data capture SHALL be a sub-module, ioctl_rd_delay.

Verification
REQ-044 Bench SHALL cover request/session: save_req pulse with ioctl_upload rising 5 cycles later at index 4 -> ioctl_upload_req high for those 5 cycles only, then ACTIVE.
REQ-045 Bench SHALL cover latency: MEM_LAT=2, memory returns 8'hA5 at address 3, ioctl_rd with addr 3 -> mem_rd in cycle +1, ioctl_din=8'hA5 in cycle +3, busy low at +3.
REQ-046 Bench SHALL cover out of range: ioctl_rd with addr 17'h1_0000 -> ioctl_din=8'hFF next cycle, mem_rd never asserted.
REQ-047 Bench SHALL cover back-to-back reads: ioctl_rd at addr 0 then addr 1 one cycle later -> two mem_rd pulses in order, ioctl_din shows byte 0 then byte 1, busy continuously high between them.
REQ-048 Bench SHALL cover abort: ioctl_upload dropped during WAIT -> ioctl_din unchanged, FSM in IDLE, done pulses once.
REQ-049 Bench SHALL cover reset mid-fetch: reset during FETCH -> all outputs at reset values, and no done pulse or ioctl_din update after release.
REQ-050 Bench SHALL cover checksum (with UPLOAD_CHECKSUM_EN): bytes 8'h80 and 8'h81 served -> checksum=8'h01.
